adc_sample_formatter: RTL and testbench

- Parametrised successor to the fixed 10-bit ADC-to-FX3 data path, running entirely in the ADC clock domain.
- Captures ADC samples (or a test ramp) and formats them into OUT_WIDTH-bit words for the downstream dual-clock FIFO.
- Two run-time modes: unpacked (signed, left-justified, one word per sample) and packed (bit-dense, no padding bits).
- Drives a write strobe into the FIFO and raises a sticky error when the FIFO cannot accept a word.

---
 rtl/adc_sample_formatter.sv | 88 ++++++++
 tb/tb_adc_sample_formatter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_formatter.sv
// adc_sample_formatter: formats ADC samples (or a test ramp) into FIFO words, unpacked or bit-packed.
// Ports:
//   adc_clock, nReset          - clock (rising edge) and async active-low reset
//   collectData                - 1 = capture and emit, 0 = idle/flush/clear error
//   testMode, packMode         - ramp source / packed format, latched when collectData rises
//   adcData                    - offset-binary sample
//   fifoFull                   - downstream FIFO cannot take a word this cycle
//   dataOut, fifoWrite         - formatted word and its one-cycle write strobe
//   bufferError                - sticky flag, a word was dropped
module adc_sample_formatter #(
    parameter int ADC_WIDTH = 10,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 adc_clock,
    input  logic                 nReset,
    input  logic                 collectData,
    input  logic                 testMode,
    input  logic                 packMode,
    input  logic [ADC_WIDTH-1:0] adcData,
    input  logic                 fifoFull,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic                 fifoWrite,
    output logic                 bufferError
);
    localparam int AW = ADC_WIDTH + OUT_WIDTH - 1;
    localparam int CW = $clog2(AW + 1);
    logic                 collect_q, test_q, pack_q, pack_d, s_vld_q, wr_q, wr_d, err_q, err_d;
    logic                 rise, test_eff, pk_emit, word_vld;
    logic [ADC_WIDTH-1:0] ramp_q, ramp_d, ramp_cur, s_q, s_d;
    logic [AW-1:0]        acc_q, acc_d, merged;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_sum;
    logic [OUT_WIDTH-1:0] data_q, data_d, unp, word;

    always_comb begin
        rise     = collectData & ~collect_q;
        // the first sample of a capture already uses the newly latched modes
        test_eff = rise ? testMode : test_q;
        pack_d   = rise ? packMode : pack_q;
        ramp_cur = rise ? '0 : ramp_q;
        ramp_d   = collectData ? ramp_cur + ADC_WIDTH'(1) : ramp_q;
        s_d      = collectData ? (test_eff ? ramp_cur : adcData) : s_q;
        // offset-binary to two's complement is an MSB flip, then left-justify
        unp      = OUT_WIDTH'(s_q ^ {1'b1, {(ADC_WIDTH-1){1'b0}}}) << (OUT_WIDTH - ADC_WIDTH);
        merged   = acc_q | (AW'(s_q) << cnt_q);
        cnt_sum  = cnt_q + CW'(ADC_WIDTH);
        pk_emit  = cnt_sum >= CW'(OUT_WIDTH);
        word_vld = s_vld_q & (~pack_q | pk_emit);
        word     = pack_q ? merged[OUT_WIDTH-1:0] : unp;
        // a falling collectData still lets the in-flight word out but drops partial bits
        acc_d    = !collectData ? '0 : (s_vld_q & pack_q) ? (pk_emit ? merged >> OUT_WIDTH : merged) : acc_q;
        cnt_d    = !collectData ? '0 : (s_vld_q & pack_q) ? (pk_emit ? cnt_sum - CW'(OUT_WIDTH) : cnt_sum) : cnt_q;
        wr_d     = word_vld & ~fifoFull;
        data_d   = wr_d ? word : data_q;
        err_d    = collectData & (err_q | (word_vld & fifoFull));
    end

    always_ff @(posedge adc_clock or negedge nReset) begin
        if (!nReset) begin
            collect_q <= 1'b0;
            test_q    <= 1'b0;
            pack_q    <= 1'b0;
            ramp_q    <= '0;
            s_q       <= '0;
            s_vld_q   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            collect_q <= collectData;
            test_q    <= test_eff;
            pack_q    <= pack_d;
            ramp_q    <= ramp_d;
            s_q       <= s_d;
            s_vld_q   <= collectData;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
        end
    end

    assign dataOut     = data_q;
    assign fifoWrite   = wr_q;
    assign bufferError = err_q;
endmodule

// File: tb/tb_adc_sample_formatter.sv
// tb_adc_sample_formatter: self-checking bench with a bit-queue reference model.
module tb_adc_sample_formatter;
    localparam int W = 10;
    localparam int O = 16;
    typedef struct { int adc; int exp; } vec_t;

    logic         clk = 0, nReset = 0, collect = 0, tmode = 0, pmode = 0, full = 0;
    logic [W-1:0] adc = '0;
    logic [O-1:0] dout;
    logic         wr, err;

    always #5 clk = ~clk;

    adc_sample_formatter #(.ADC_WIDTH(W), .OUT_WIDTH(O)) dut (
        .adc_clock(clk), .nReset(nReset), .collectData(collect), .testMode(tmode),
        .packMode(pmode), .adcData(adc), .fifoFull(full), .dataOut(dout),
        .fifoWrite(wr), .bufferError(err)
    );

    int checks = 0, errors = 0, nwr = 0;
    int words[$];
    int m_prev, m_t, m_p, m_ramp, m_hs, m_s, m_data, m_wr, m_err;
    bit bq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_t = 0; m_p = 0; m_ramp = 0; m_hs = 0; m_s = 0;
        m_data = 0; m_wr = 0; m_err = 0;
        bq.delete();
    endtask

    // one clock edge of the behavioural model: the packed stream is a plain bit queue
    task automatic model_edge();
        int word = 0;
        bit ready = 0;
        if (m_hs != 0) begin
            if (m_p != 0) begin
                for (int i = 0; i < W; i++) bq.push_back(bit'((m_s >> i) & 1));
                if (bq.size() >= O) begin
                    for (int i = 0; i < O; i++) word |= int'(bq.pop_front()) << i;
                    ready = 1;
                end
            end else begin
                word = ((m_s - (1 << (W - 1))) << (O - W)) & ((1 << O) - 1);
                ready = 1;
            end
        end
        if (!collect) bq.delete();
        m_wr = int'(ready && !full);
        if (m_wr != 0) m_data = word;
        m_err = collect ? int'((m_err != 0) || (ready && full)) : 0;
        if (collect && m_prev == 0) begin
            m_t = int'(tmode); m_p = int'(pmode); m_ramp = 0;
        end
        if (collect) begin
            m_s = (m_t != 0) ? m_ramp : int'(adc);
            m_ramp = (m_ramp + 1) % (1 << W);
            m_hs = 1;
        end else m_hs = 0;
        m_prev = int'(collect);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("dataOut", int'(dout), m_data);
        chk("fifoWrite", int'(wr), m_wr);
        chk("bufferError", int'(err), m_err);
        if (wr) begin nwr++; words.push_back(int'(dout)); end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        #2 nReset = 0;
        #1;
        model_reset();
        chk("rst_dataOut", int'(dout), 0);
        chk("rst_fifoWrite", int'(wr), 0);
        chk("rst_bufferError", int'(err), 0);
        collect = 0;
        @(posedge clk);
        #1 nReset = 1;
    endtask

    initial begin
        vec_t tbl[6];
        int   pk_exp[5];
        int   s0, s1, n0;
        tbl[0] = '{512, 'h0000}; tbl[1] = '{0, 'h8000};   tbl[2] = '{1023, 'h7FC0};
        tbl[3] = '{513, 'h0040}; tbl[4] = '{511, 'hFFC0}; tbl[5] = '{1, 'h8040};
        pk_exp = '{'h0400, 'hC020, 'h0400, 'h6014, 'h01C0};
        model_reset();
        #1;
        chk("rst_dataOut", int'(dout), 0);
        chk("rst_fifoWrite", int'(wr), 0);
        chk("rst_bufferError", int'(err), 0);
        repeat (2) @(posedge clk);
        #1 nReset = 1;

        // unpacked ramp across a full wrap
        tmode = 1; pmode = 0; collect = 1; nwr = 0;
        for (int i = 0; i < 1030; i++) begin
            step();
            if (i == 0) chk("ramp_first_idle", int'(wr), 0);
            if (i == 1) chk("ramp_first_word", int'(dout), 'h8000);
            if (i == 2) chk("ramp_second_word", int'(dout), 'h8040);
            if (i == 1024) chk("ramp_top", int'(dout), 'h7FC0);
            if (i == 1025) chk("ramp_wrap", int'(dout), 'h8000);
        end
        collect = 0;
        step();
        chk("ramp_in_flight", int'(wr), 1);
        steps(2);
        chk("ramp_no_write", int'(wr), 0);
        chk("ramp_count", nwr, 1030);

        // fixed-value unpacked table
        tmode = 0; pmode = 0; collect = 1;
        foreach (tbl[k]) begin
            adc = W'(tbl[k].adc);
            steps(2);
            chk("unp_tbl", int'(dout), tbl[k].exp);
        end
        collect = 0; steps(2);

        // fifoFull for 3 cycles mid-stream
        tmode = 1; collect = 1; nwr = 0;
        for (int i = 0; i < 20; i++) begin
            full = (i >= 8 && i < 11);
            step();
        end
        full = 0;
        chk("ovf_sticky", int'(err), 1);
        collect = 0;
        step();
        chk("ovf_cleared", int'(err), 0);
        steps(2);
        chk("ovf_count", nwr, 17);

        // packed ramp, 8 samples
        tmode = 1; pmode = 1; collect = 1; nwr = 0; words.delete();
        steps(8);
        collect = 0;
        steps(4);
        chk("pk_count", nwr, 5);
        for (int k = 0; k < 5; k++) chk("pk_word", (k < words.size()) ? words[k] : -1, pk_exp[k]);

        // packed, drop after 3 samples, then restart clean
        tmode = 0; pmode = 1; collect = 1; nwr = 0; words.delete();
        s0 = int'($urandom_range(0, 1023)); adc = W'(s0); step();
        s1 = int'($urandom_range(0, 1023)); adc = W'(s1); step();
        adc = W'($urandom); step();
        collect = 0; steps(3);
        chk("pk_drop_count", nwr, 1);
        chk("pk_drop_word", (words.size() > 0) ? words[0] : -1, ((s1 & 'h3F) << 10) | s0);
        collect = 1; nwr = 0; words.delete();
        n0 = int'($urandom_range(0, 1023)); adc = W'(n0); step();
        for (int i = 0; i < 3; i++) begin adc = W'($urandom); step(); end
        collect = 0; steps(3);
        chk("pk_restart_count", nwr, 2);
        chk("pk_restart_s0", (words.size() > 0) ? (words[0] & 'h3FF) : -1, n0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) collect = ~collect;
            tmode = 1'($urandom); pmode = 1'($urandom);
            full = ($urandom_range(0, 4) == 0);
            adc = W'($urandom);
            step();
        end
        full = 0; collect = 0; steps(3);

        // reset mid packed stream, then ramp restarts at 0
        tmode = 1; pmode = 1; collect = 1;
        steps(5);
        pulse_reset();
        tmode = 1; pmode = 0; collect = 1;
        steps(2);
        chk("rst_ramp_restart", int'(dout), 'h8000);
        collect = 0; steps(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
